irq_request_unit: RTL

- Collects interrupt sources: NoC network-interface spike-arrival, timer and DMA-done lines.
- Edge-detects and latches each source as pending, masks and prioritises them, and presents a single held request with a cause code to the CPU interrupt controller (consumer of interrupt_signal).
- Holds the request until the controller acknowledges ISR entry, then blocks further requests until the ISR returns.
- Counts interrupt edges lost because the source was already pending.

---
 rtl/irq_request_unit_if.sv | 24 ++
 rtl/irq_request_unit.sv | 123 ++++++++++++
 2 files changed

// File: rtl/irq_request_unit_if.sv
// Request/acknowledge handshake between the interrupt request unit and the CPU interrupt controller.
// The unit drives the held request and its cause; the controller answers with ISR entry and return pulses.
interface irq_request_unit_if #(
  parameter int CAUSE_W = 3
);
  logic               interrupt_signal;
  logic [CAUSE_W-1:0] irq_cause;
  logic               irq_ack;
  logic               isr_done;

  modport master (
    output interrupt_signal,
    output irq_cause,
    input  irq_ack,
    input  isr_done
  );

  modport slave (
    input  interrupt_signal,
    input  irq_cause,
    output irq_ack,
    output isr_done
  );
endinterface

// File: rtl/irq_request_unit.sv
// Interrupt request unit: edge-latches sources into pending, masks and prioritises them (index 0 highest),
// and holds one request with its cause until the controller enters the ISR; no nesting until the ISR returns.
module irq_request_unit #(
  parameter int                 NUM_SRC    = 8,
  parameter int                 CNT_W      = 8,
  parameter logic [NUM_SRC-1:0] MASK_RESET = {NUM_SRC{1'b1}}
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               mie,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  output logic [NUM_SRC-1:0] mask,
  output logic [NUM_SRC-1:0] pending,
  input  logic               lost_clr,
  output logic [CNT_W-1:0]   lost_count,
  irq_request_unit_if.master irq
);
  localparam int CAUSE_W = $clog2(NUM_SRC);

  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    IN_SERVICE
  } state_t;

  state_t             state_reg, state_next;
  logic [NUM_SRC-1:0] irq_prev_reg;
  logic [NUM_SRC-1:0] pending_reg, pending_next;
  logic [NUM_SRC-1:0] mask_reg, mask_next;
  logic [NUM_SRC-1:0] edge_det, ack_clr, lost_hit, eligible;
  logic [CNT_W-1:0]   lost_reg, lost_next;
  logic               req_reg, req_next;
  logic [CAUSE_W-1:0] cause_reg, cause_next, winner;
  logic               ack_fire;

  // Only the acknowledge of an outstanding request clears a pending bit.
  assign ack_fire = (state_reg == REQUEST) && irq.irq_ack;
  assign eligible = pending_reg & mask_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign edge_det[gi]     = irq_src[gi] & ~irq_prev_reg[gi];
      assign ack_clr[gi]      = ack_fire && (cause_reg == CAUSE_W'(gi));
      // A new edge wins over the acknowledge clear of the same bit.
      assign pending_next[gi] = (pending_reg[gi] & ~ack_clr[gi]) | edge_det[gi];
      assign lost_hit[gi]     = edge_det[gi] & pending_reg[gi] & ~ack_clr[gi];
    end
  endgenerate

  always_comb begin
    winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) winner = CAUSE_W'(i);
    end
  end

  always_comb begin
    mask_next = mask_we ? mask_wdata : mask_reg;
    lost_next = lost_reg;
    if (lost_clr) begin
      lost_next = '0;
    end else if ((|lost_hit) && (lost_reg != {CNT_W{1'b1}})) begin
      lost_next = lost_reg + CNT_W'(1);
    end
  end

  always_comb begin
    state_next = state_reg;
    req_next   = req_reg;
    cause_next = cause_reg;
    case (state_reg)
      IDLE: begin
        if (mie && (|eligible)) begin
          state_next = REQUEST;
          req_next   = 1'b1;
          cause_next = winner;
        end
      end
      REQUEST: begin
        if (irq.irq_ack) begin
          state_next = IN_SERVICE;
          req_next   = 1'b0;
        end
      end
      IN_SERVICE: begin
        if (irq.isr_done) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        req_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= IDLE;
      irq_prev_reg <= '1;
      pending_reg  <= '0;
      mask_reg     <= MASK_RESET;
      lost_reg     <= '0;
      req_reg      <= 1'b0;
      cause_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      irq_prev_reg <= irq_src;
      pending_reg  <= pending_next;
      mask_reg     <= mask_next;
      lost_reg     <= lost_next;
      req_reg      <= req_next;
      cause_reg    <= cause_next;
    end
  end

  assign mask                 = mask_reg;
  assign pending              = pending_reg;
  assign lost_count           = lost_reg;
  assign irq.interrupt_signal = req_reg;
  assign irq.irq_cause        = cause_reg;
endmodule
